// File: rtl/glb_pkg.sv
// Shared widths, write-request payload and SRAM arbitration opcodes for the GLB responder.
package glb_pkg;

  localparam int unsigned GLB_ADDR_W = 14;
  localparam int unsigned GLB_DATA_W = 32;

  // Longest run of back-to-back read cycles the engine may issue.
  localparam int unsigned RD_RUN_MAX = 64;

  typedef struct packed {
    logic [GLB_ADDR_W-1:0] addr;
    logic [GLB_DATA_W-1:0] data;
  } glb_wreq_t;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_READ    = 2'd1,
    OP_WDRAIN  = 2'd2,
    OP_WDIRECT = 2'd3
  } sram_op_e;

endpackage

// File: rtl/glb_wbuf.sv
// One-entry write buffer: parks a write that lost arbitration to a read and
// exposes an address compare so later reads can be forwarded from it.
module glb_wbuf
  import glb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = GLB_ADDR_W,
  parameter int unsigned DATA_WIDTH = GLB_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic [ADDR_WIDTH-1:0] cap_addr,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  drain,
  input  logic [ADDR_WIDTH-1:0] cmp_addr,
  output logic                  vld,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  hit_c
);

  // Valid bit: a capture wins over a drain in the same cycle (drain-and-refill).
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
    end else if (capture) begin
      vld <= 1'b1;
    end else if (drain) begin
      vld <= 1'b0;
    end
  end

  // Payload registers load on capture only.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      data <= '0;
    end else if (capture) begin
      addr <= cap_addr;
      data <= cap_data;
    end
  end

  // Address compare for the read-forward path.
  always_comb begin
    hit_c = vld && (addr == cmp_addr);
  end

endmodule

// File: rtl/glb_sram_responder.sv
// GLB-side responder: arbitrates engine reads and writes onto one single-port
// SRAM with 1-cycle read latency. Reads win; colliding writes are parked in a
// one-entry buffer, drained on the next free cycle and forwarded to reads.
module glb_sram_responder
  import glb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = GLB_ADDR_W,
  parameter int unsigned DATA_WIDTH = GLB_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  glb_read_ready,
  input  logic [ADDR_WIDTH-1:0] glb_read_addr,
  output logic                  glb_read_valid,
  output logic [DATA_WIDTH-1:0] glb_read_data,
  input  logic                  glb_write_ready,
  input  logic                  WEB,
  input  logic [ADDR_WIDTH-1:0] glb_write_addr,
  input  logic [DATA_WIDTH-1:0] glb_write_data,
  output logic                  glb_write_valid,
  input  logic                  flush,
  output logic                  wbuf_empty,
  output logic                  sram_ceb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam int unsigned RUN_W = 7;

  logic                  rd_req_c;
  logic                  wr_req_c;
  logic                  capture_c;
  logic                  drain_c;
  sram_op_e              op_c;

  logic                  wbuf_vld;
  logic [ADDR_WIDTH-1:0] wbuf_addr;
  logic [DATA_WIDTH-1:0] wbuf_data;
  logic                  wbuf_hit_c;

  logic                  rd_pend;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [RUN_W-1:0]      rd_run;

  glb_wbuf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wbuf (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture_c),
    .cap_addr (glb_write_addr),
    .cap_data (glb_write_data),
    .drain    (drain_c),
    .cmp_addr (glb_read_addr),
    .vld      (wbuf_vld),
    .addr     (wbuf_addr),
    .data     (wbuf_data),
    .hit_c    (wbuf_hit_c)
  );

  // Request decode and per-cycle priority arbitration: read, drain, direct write.
  // A request still held during its ack cycle is the same write and is ignored.
  always_comb begin
    rd_req_c  = glb_read_ready;
    wr_req_c  = glb_write_ready && !WEB && !glb_write_valid;
    op_c      = OP_IDLE;
    if (!rst) begin
      if (rd_req_c) begin
        op_c = OP_READ;
      end else if (wbuf_vld) begin
        op_c = OP_WDRAIN;
      end else if (wr_req_c) begin
        op_c = OP_WDIRECT;
      end
    end
    drain_c   = (op_c == OP_WDRAIN);
    capture_c = !rst && wr_req_c && ((rd_req_c && !wbuf_vld) || drain_c);
  end

  // SRAM port drive for the chosen op; idle pattern otherwise.
  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_addr = '0;
    sram_din  = '0;
    unique case (op_c)
      OP_READ: begin
        sram_ceb  = 1'b0;
        sram_addr = glb_read_addr;
      end
      OP_WDRAIN: begin
        sram_ceb  = 1'b0;
        sram_web  = 1'b0;
        sram_addr = wbuf_addr;
        sram_din  = wbuf_data;
      end
      OP_WDIRECT: begin
        sram_ceb  = 1'b0;
        sram_web  = 1'b0;
        sram_addr = glb_write_addr;
        sram_din  = glb_write_data;
      end
      default: begin
      end
    endcase
  end

  // Response pipeline: read pending/forward state and the write ack pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend         <= 1'b0;
      fwd_hit         <= 1'b0;
      fwd_data        <= '0;
      glb_write_valid <= 1'b0;
    end else begin
      rd_pend         <= rd_req_c;
      fwd_hit         <= rd_req_c && wbuf_hit_c;
      fwd_data        <= wbuf_data;
      glb_write_valid <= capture_c || (op_c == OP_WDIRECT);
    end
  end

  // Consecutive read-cycle counter, saturating, for the engine protocol check.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_run <= '0;
    end else if (rd_req_c) begin
      if (rd_run != {RUN_W{1'b1}}) begin
        rd_run <= rd_run + RUN_W'(1);
      end
    end else begin
      rd_run <= '0;
    end
  end

  // Engine protocol and drain-ordering checks.
  always_ff @(posedge clk) begin
    if (!rst && rd_req_c) begin
      assert (rd_run < RUN_W'(RD_RUN_MAX));
    end
    if (!rst && flush && wbuf_vld) begin
      assert (op_c != OP_WDIRECT);
    end
  end

  assign glb_read_valid = rd_pend;
  assign wbuf_empty     = !wbuf_vld;

  // Read data: forward from the buffer snapshot, else the SRAM output; zero when idle.
  always_comb begin
    glb_read_data = '0;
    if (rd_pend) begin
      glb_read_data = fwd_hit ? fwd_data : sram_dout;
    end
  end

endmodule
